letter_tx_queue: RTL and testbench

LETTER_TX_QUEUE -- requirements
Module: letter_tx_queue

---
 rtl/letter_tx_queue.sv | 162 ++++++++++++++++
 tb/tb_letter_tx_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/letter_tx_queue.sv
// Letter queue feeding an IR transmitter; a retained history can be replayed. A write reaches tx_valid_out 4 cycles later.
// Writes are dropped when full, which sets a sticky overflow flag. Each letter is held until tx_busy_in rises and falls again.
module letter_tx_queue #(
  parameter  int DATA_WIDTH = 5,
  parameter  int DEPTH      = 1000,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  data_valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  flush_in,
  input  logic                  retain_in,
  input  logic                  replay_in,
  input  logic                  tx_busy_in,
  output logic                  tx_valid_out,
  output logic [DATA_WIDTH-1:0] tx_data_out,
  output logic [CNT_WIDTH-1:0]  pending_out,
  output logic [CNT_WIDTH-1:0]  stored_out,
  output logic                  full_out,
  output logic                  empty_out,
  output logic                  overflow_out
);

  typedef enum logic [2:0] {IDLE, FETCH1, FETCH2, SEND, WAIT_DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  ONE_CNT   = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_dat_q, ram_dat_q;

  state_e                state_q;
  logic                  tx_valid_q;
  logic [DATA_WIDTH-1:0] tx_data_q;

  logic [ADDR_WIDTH-1:0] base_q, base_d, rd_q, rd_d, wr_q, wr_d;
  logic [CNT_WIDTH-1:0]  pending_q, pending_d, stored_q, stored_d;
  logic                  overflow_q, overflow_d, replay_pend_q, replay_pend_d;

  logic                  full, wr_en, start, done, replay_idle;
  logic [ADDR_WIDTH-1:0] rd_inc;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign full        = (stored_q == DEPTH_CNT);
  assign wr_en       = data_valid_in && !full && !flush_in && rst_in;
  // A rewind in IDLE moves rd this cycle, so the fetch waits one cycle for the new address.
  assign replay_idle = (state_q == IDLE) && replay_in && (stored_q != pending_q);
  assign start       = (state_q == IDLE) && !replay_idle && (pending_q != '0) && !tx_busy_in;
  assign done        = (state_q == WAIT_DONE) && !tx_busy_in;
  assign rd_inc      = ptr_inc(rd_q);

  always_comb begin
    base_d        = base_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    pending_d     = pending_q;
    stored_d      = stored_q;
    overflow_d    = overflow_q || (data_valid_in && full);
    replay_pend_d = replay_pend_q || (replay_in && (state_q != IDLE));

    if (replay_idle) begin
      rd_d      = base_q;
      pending_d = stored_q;
    end else if (done) begin
      replay_pend_d = 1'b0;
      // Without retention the sent letter is freed: base jumps to the new rd.
      base_d   = retain_in ? base_q : rd_inc;
      stored_d = retain_in ? stored_q : pending_q - ONE_CNT;
      if (replay_pend_q || replay_in) begin
        rd_d      = retain_in ? base_q : rd_inc;
        pending_d = stored_d;
      end else begin
        rd_d      = rd_inc;
        pending_d = pending_q - ONE_CNT;
      end
    end

    if (wr_en) begin
      wr_d      = ptr_inc(wr_q);
      pending_d = pending_d + ONE_CNT;
      stored_d  = stored_d + ONE_CNT;
    end

    if (flush_in) begin
      base_d        = '0;
      rd_d          = '0;
      wr_d          = '0;
      pending_d     = '0;
      stored_d      = '0;
      overflow_d    = 1'b0;
      replay_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      base_q        <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      pending_q     <= '0;
      stored_q      <= '0;
      overflow_q    <= 1'b0;
      replay_pend_q <= 1'b0;
    end else begin
      base_q        <= base_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      pending_q     <= pending_d;
      stored_q      <= stored_d;
      overflow_q    <= overflow_d;
      replay_pend_q <= replay_pend_d;
    end
  end

  // Storage is never reset; only written slots are ever fetched.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wr_q] <= data_in;
    if (start) rd_dat_q <= mem_q[rd_q];
    ram_dat_q <= rd_dat_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in || flush_in) begin
      state_q    <= IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE:      if (start) state_q <= FETCH1;
        FETCH1:    state_q <= FETCH2;
        FETCH2: begin
          state_q    <= SEND;
          tx_valid_q <= 1'b1;
          tx_data_q  <= ram_dat_q;
        end
        SEND: begin
          if (tx_busy_in) begin
            state_q    <= WAIT_DONE;
            tx_valid_q <= 1'b0;
          end
        end
        WAIT_DONE: if (!tx_busy_in) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign tx_valid_out = tx_valid_q;
  assign tx_data_out  = tx_data_q;
  assign pending_out  = pending_q;
  assign stored_out   = stored_q;
  assign full_out     = full;
  assign empty_out    = (pending_q == '0);
  assign overflow_out = overflow_q;

endmodule

// File: tb/tb_letter_tx_queue.sv
// Bench for letter_tx_queue at DEPTH=4: latency/handshake, overflow, wrap, replay, flush and reset sequences.
module tb_letter_tx_queue;
  localparam int DW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_in = 1'b0;
  logic          rst_in, data_valid_in, flush_in, retain_in, replay_in, tx_busy_in;
  logic [DW-1:0] data_in;
  logic          tx_valid_out, full_out, empty_out, overflow_out;
  logic [DW-1:0] tx_data_out;
  logic [CW-1:0] pending_out, stored_out;

  always #5 clk_in = ~clk_in;

  letter_tx_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(data_valid_in), .data_in(data_in),
    .flush_in(flush_in), .retain_in(retain_in), .replay_in(replay_in), .tx_busy_in(tx_busy_in),
    .tx_valid_out(tx_valid_out), .tx_data_out(tx_data_out), .pending_out(pending_out),
    .stored_out(stored_out), .full_out(full_out), .empty_out(empty_out), .overflow_out(overflow_out)
  );

  typedef struct {
    logic [DW-1:0] dat;
    int            exp_stored;
    int            exp_full;
    int            exp_ovf;
    bit            kept;
  } ovf_vec_t;

  ovf_vec_t vecs[6];
  int       exp_q[$];
  int       n_pass = 0;
  int       n_total = 0;
  int       max_stored = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    if (int'(stored_out) > max_stored) max_stored = int'(stored_out);
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_valid_out) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk({name, "_timeout"}, int'(tx_valid_out), 1);
  endtask

  // Transmitter model: accept one letter, check it against the scoreboard, then run busy.
  task automatic tx_one(input string name, input int busy_cycles);
    bit ok;
    int exp;
    wait_valid(name, ok);
    if (!ok) return;
    if (exp_q.size() == 0) begin
      chk({name, "_unexpected"}, int'(tx_data_out), -1);
      return;
    end
    exp = exp_q.pop_front();
    chk(name, int'(tx_data_out), exp);
    tx_busy_in = 1'b1;
    repeat (busy_cycles) step();
    tx_busy_in = 1'b0;
    step();
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_tx_valid"}, int'(tx_valid_out), 0);
    chk({pfx, "_tx_data"},  int'(tx_data_out), 0);
    chk({pfx, "_pending"},  int'(pending_out), 0);
    chk({pfx, "_stored"},   int'(stored_out), 0);
    chk({pfx, "_full"},     int'(full_out), 0);
    chk({pfx, "_empty"},    int'(empty_out), 1);
    chk({pfx, "_overflow"}, int'(overflow_out), 0);
  endtask

  task automatic chk_latency(input string pfx, input logic [DW-1:0] letter);
    data_valid_in = 1'b1;
    data_in       = letter;
    step();
    data_valid_in = 1'b0;
    chk({pfx, "_pending"}, int'(pending_out), 1);
    chk({pfx, "_n1"}, int'(tx_valid_out), 0);
    step();
    chk({pfx, "_n2"}, int'(tx_valid_out), 0);
    step();
    chk({pfx, "_n3"}, int'(tx_valid_out), 0);
    step();
    chk({pfx, "_n4_valid"}, int'(tx_valid_out), 1);
    chk({pfx, "_n4_data"}, int'(tx_data_out), int'(letter));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    bit ok;
    int guard;

    vecs[0] = '{5'd1, 1, 0, 0, 1'b1};
    vecs[1] = '{5'd2, 2, 0, 0, 1'b1};
    vecs[2] = '{5'd3, 3, 0, 0, 1'b1};
    vecs[3] = '{5'd4, 4, 1, 0, 1'b1};
    vecs[4] = '{5'd5, 4, 1, 1, 1'b0};
    vecs[5] = '{5'd6, 4, 1, 1, 1'b0};

    rst_in = 1'b0; data_valid_in = 1'b0; data_in = '0; flush_in = 1'b0;
    retain_in = 1'b0; replay_in = 1'b0; tx_busy_in = 1'b0;
    step();
    step();
    chk_reset_state("reset");
    rst_in = 1'b1;

    // Latency and busy handshake.
    chk_latency("lat", 5'd7);
    tx_busy_in = 1'b1;
    repeat (3) step();
    chk("hs_valid_drop", int'(tx_valid_out), 0);
    chk("hs_data_hold", int'(tx_data_out), 7);
    chk("hs_pending_busy", int'(pending_out), 1);
    tx_busy_in = 1'b0;
    step();
    chk("hs_pending_done", int'(pending_out), 0);
    chk("hs_empty", int'(empty_out), 1);

    // Full/overflow with transmitter stalled.
    retain_in  = 1'b1;
    tx_busy_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_valid_in = 1'b1;
      data_in       = vecs[i].dat;
      if (vecs[i].kept) exp_q.push_back(int'(vecs[i].dat));
      step();
      chk($sformatf("ovf_stored%0d", i), int'(stored_out), vecs[i].exp_stored);
      chk($sformatf("ovf_full%0d", i), int'(full_out), vecs[i].exp_full);
      chk($sformatf("ovf_flag%0d", i), int'(overflow_out), vecs[i].exp_ovf);
    end
    data_valid_in = 1'b0;
    tx_busy_in    = 1'b0;
    for (int i = 0; i < 4; i++) tx_one($sformatf("ovf_tx%0d", i), 1);
    repeat (6) step();
    chk("ovf_no_extra_tx", int'(tx_valid_out), 0);
    chk("ovf_pending", int'(pending_out), 0);
    chk("ovf_retained", int'(stored_out), 4);
    chk("ovf_sticky", int'(overflow_out), 1);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    chk("ovf_flush_stored", int'(stored_out), 0);
    chk("ovf_flush_flag", int'(overflow_out), 0);

    // Wrap-around streaming without retention.
    retain_in  = 1'b0;
    max_stored = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          guard = 0;
          while (full_out && guard < 200) begin
            step();
            guard++;
          end
          data_valid_in = 1'b1;
          data_in       = DW'(i);
          exp_q.push_back(i);
          step();
          data_valid_in = 1'b0;
        end
      end
      begin
        for (int j = 0; j < 10; j++) tx_one($sformatf("wrap_tx%0d", j), 2);
      end
    join
    chk("wrap_peak_stored", max_stored, DEPTH);
    chk("wrap_pending", int'(pending_out), 0);
    chk("wrap_stored", int'(stored_out), 0);

    // Replay during the last letter's WAIT_DONE.
    retain_in     = 1'b1;
    data_valid_in = 1'b1;
    for (int i = 10; i < 13; i++) begin
      data_in = DW'(i);
      exp_q.push_back(i);
      step();
    end
    data_valid_in = 1'b0;
    tx_one("rep_A", 1);
    tx_one("rep_B", 1);
    wait_valid("rep_C", ok);
    if (ok) begin
      chk("rep_C", int'(tx_data_out), (exp_q.size() > 0) ? exp_q.pop_front() : -1);
      tx_busy_in = 1'b1;
      step();
      replay_in = 1'b1;
      step();
      replay_in = 1'b0;
      chk("rep_C_wait_pending", int'(pending_out), 1);
      tx_busy_in = 1'b0;
      step();
      chk("rep_rewound_pending", int'(pending_out), 3);
    end
    for (int i = 10; i < 13; i++) exp_q.push_back(i);
    for (int i = 0; i < 3; i++) tx_one($sformatf("rep_again%0d", i), 1);
    chk("rep_done_pending", int'(pending_out), 0);
    chk("rep_done_stored", int'(stored_out), 3);
    tx_busy_in = 1'b1;
    replay_in  = 1'b1;
    step();
    replay_in = 1'b0;
    chk("idle_replay_pending", int'(pending_out), 3);
    flush_in = 1'b1;
    step();
    flush_in   = 1'b0;
    tx_busy_in = 1'b0;
    exp_q.delete();

    // Flush mid-transfer with a same-cycle write.
    tx_busy_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_valid_in = 1'b1;
      data_in       = DW'(20 + i);
      step();
    end
    data_valid_in = 1'b0;
    chk("fl_ovf_before", int'(overflow_out), 1);
    tx_busy_in = 1'b0;
    wait_valid("fl_send", ok);
    flush_in      = 1'b1;
    data_valid_in = 1'b1;
    data_in       = 5'd31;
    step();
    flush_in      = 1'b0;
    data_valid_in = 1'b0;
    chk("fl_tx_valid", int'(tx_valid_out), 0);
    chk("fl_pending", int'(pending_out), 0);
    chk("fl_stored", int'(stored_out), 0);
    chk("fl_overflow", int'(overflow_out), 0);
    repeat (6) step();
    chk("fl_quiet_valid", int'(tx_valid_out), 0);
    chk("fl_quiet_empty", int'(empty_out), 1);

    // Reset during WAIT_DONE, then a fresh write.
    data_valid_in = 1'b1;
    data_in       = 5'd9;
    step();
    data_valid_in = 1'b0;
    wait_valid("rst_send", ok);
    tx_busy_in = 1'b1;
    step();
    rst_in = 1'b0;
    step();
    rst_in     = 1'b1;
    tx_busy_in = 1'b0;
    chk_reset_state("rst_wait");
    chk_latency("rst_lat", 5'd3);
    tx_busy_in = 1'b1;
    step();
    tx_busy_in = 1'b0;
    step();
    chk("rst_lat_empty", int'(empty_out), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
